execute_unit: RTL and testbench

EXECUTE_UNIT -- requirements
Module: execute_unit

---
 rtl/execute_unit.sv | 153 +++++++++++++++
 tb/tb_execute_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// Multi-cycle execute unit. It reads two operands from an external register file,
// runs one ALU operation and writes the result back.
//
// state | meaning
// IDLE  | ready for an instruction; accepts it when instr_valid is high
// READ  | register-file read cycle (enable=1, load=0)
// EXEC  | operands are valid; result and flags are registered on the exit edge
// WRITE | register-file write cycle (enable=1, load=1)
module execute_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [17:0] instr,
  output logic [3:0]  reg_to_read1,
  output logic [3:0]  reg_to_read2,
  input  logic [17:0] data_to_read1,
  input  logic [17:0] data_to_read2,
  output logic [3:0]  reg_to_write,
  output logic [17:0] data_to_write,
  output logic        enable,
  output logic        load,
  output logic        zero_flag,
  output logic        carry_flag,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] instr_q, instr_d;
  logic [17:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  opcode;
  logic [17:0] op_a, op_b, imm_ext;
  logic [18:0] sum;
  logic [17:0] alu_res;
  logic        alu_carry;
  logic        op_legal;

  assign opcode  = instr_q[17:14];
  assign op_a    = data_to_read1;
  assign op_b    = data_to_read2;
  assign imm_ext = {{12{instr_q[5]}}, instr_q[5:0]};

  always_comb begin
    sum       = 19'd0;
    alu_res   = 18'd0;
    alu_carry = 1'b0;
    op_legal  = 1'b1;
    case (opcode)
      4'd0: begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = sum[17:0];
        alu_carry = sum[18];
      end
      4'd1: begin
        alu_res   = op_a - op_b;
        alu_carry = (op_a < op_b);
      end
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: begin
        // Carry treats the sign-extended immediate as an 18-bit unsigned addend.
        sum       = {1'b0, op_a} + {1'b0, imm_ext};
        alu_res   = sum[17:0];
        alu_carry = sum[18];
      end
      4'd6: alu_res = op_a;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        if (op_legal) begin
          result_d = alu_res;
          zero_d   = (alu_res == 18'd0);
          carry_d  = alu_carry;
          state_d  = WRITE;
        end else begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= 18'd0;
      result_q  <= 18'd0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes come straight from the state register, so load cannot appear outside WRITE.
  assign instr_ready   = (state_q == IDLE);
  assign enable        = (state_q == READ) || (state_q == WRITE);
  assign load          = (state_q == WRITE);
  assign reg_to_read1  = instr_q[9:6];
  assign reg_to_read2  = instr_q[5:2];
  assign reg_to_write  = instr_q[13:10];
  assign data_to_write = result_q;
  assign zero_flag     = zero_q;
  assign carry_flag    = carry_q;
  assign done          = done_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: behavioural register file plus hand-computed
// expectations for each instruction, reset and throughput scenario.
module tb_execute_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [17:0] instr;
  logic [3:0]  reg_to_read1, reg_to_read2, reg_to_write;
  logic [17:0] data_to_read1, data_to_read2, data_to_write;
  logic        enable, load, zero_flag, carry_flag, done, illegal;

  int n_chk = 0;
  int n_bad = 0;

  logic [17:0] rf [16];

  execute_unit dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .reg_to_read1(reg_to_read1), .reg_to_read2(reg_to_read2),
    .data_to_read1(data_to_read1), .data_to_read2(data_to_read2),
    .reg_to_write(reg_to_write), .data_to_write(data_to_write),
    .enable(enable), .load(load),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Register file with registered read data and write on load.
  always @(posedge clock) begin
    if (enable) begin
      data_to_read1 <= rf[reg_to_read1];
      data_to_read2 <= rf[reg_to_read2];
      if (load) rf[reg_to_write] <= data_to_write;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic [3:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 2'b00};
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (instr_ready !== 1'b1 && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic accept(input logic [17:0] ins);
    wait_ready();
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr       = 18'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [17:0] ins,
                        input logic [17:0] exp_d, input logic exp_z, input logic exp_c);
    accept(ins);
    @(negedge clock);
    chk({tag, ".rd_en"},   {31'd0, enable}, 32'd1);
    chk({tag, ".rd_ld"},   {31'd0, load}, 32'd0);
    chk({tag, ".rd_rdy"},  {31'd0, instr_ready}, 32'd0);
    chk({tag, ".rd_a1"},   {28'd0, reg_to_read1}, {28'd0, ins[9:6]});
    chk({tag, ".rd_a2"},   {28'd0, reg_to_read2}, {28'd0, ins[5:2]});
    @(negedge clock);
    chk({tag, ".ex_en"},   {31'd0, enable}, 32'd0);
    chk({tag, ".ex_ld"},   {31'd0, load}, 32'd0);
    @(negedge clock);
    chk({tag, ".wr_en"},   {31'd0, enable}, 32'd1);
    chk({tag, ".wr_ld"},   {31'd0, load}, 32'd1);
    chk({tag, ".wr_dst"},  {28'd0, reg_to_write}, {28'd0, ins[13:10]});
    chk({tag, ".wr_data"}, {14'd0, data_to_write}, {14'd0, exp_d});
    chk({tag, ".wr_zero"}, {31'd0, zero_flag}, {31'd0, exp_z});
    chk({tag, ".wr_cy"},   {31'd0, carry_flag}, {31'd0, exp_c});
    chk({tag, ".wr_done"}, {31'd0, done}, 32'd0);
    @(negedge clock);
    chk({tag, ".done"},    {31'd0, done}, 32'd1);
    chk({tag, ".rdy"},     {31'd0, instr_ready}, 32'd1);
    chk({tag, ".id_ld"},   {31'd0, load}, 32'd0);
  endtask

  task automatic run_illegal(input string tag, input logic [17:0] ins,
                             input logic [17:0] prev_d, input logic prev_z, input logic prev_c);
    accept(ins);
    @(negedge clock);
    chk({tag, ".rd_ld"},  {31'd0, load}, 32'd0);
    @(negedge clock);
    chk({tag, ".ex_ld"},  {31'd0, load}, 32'd0);
    chk({tag, ".ex_ill"}, {31'd0, illegal}, 32'd0);
    @(negedge clock);
    chk({tag, ".ill"},    {31'd0, illegal}, 32'd1);
    chk({tag, ".rdy"},    {31'd0, instr_ready}, 32'd1);
    chk({tag, ".ld"},     {31'd0, load}, 32'd0);
    chk({tag, ".done"},   {31'd0, done}, 32'd0);
    chk({tag, ".data"},   {14'd0, data_to_write}, {14'd0, prev_d});
    chk({tag, ".zero"},   {31'd0, zero_flag}, {31'd0, prev_z});
    chk({tag, ".cy"},     {31'd0, carry_flag}, {31'd0, prev_c});
    @(negedge clock);
    chk({tag, ".ill_end"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_load;
    for (int i = 0; i < 16; i++) rf[i] = 18'd0;
    data_to_read1 = 18'd0;
    data_to_read2 = 18'd0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 18'd0;
    repeat (2) @(negedge clock);
    chk("rst.rdy",  {31'd0, instr_ready}, 32'd1);
    chk("rst.en",   {31'd0, enable}, 32'd0);
    chk("rst.ld",   {31'd0, load}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.ill",  {31'd0, illegal}, 32'd0);
    chk("rst.zero", {31'd0, zero_flag}, 32'd0);
    chk("rst.cy",   {31'd0, carry_flag}, 32'd0);
    chk("rst.data", {14'd0, data_to_write}, 32'd0);
    chk("rst.dst",  {28'd0, reg_to_write}, 32'd0);

    rf[1] = 18'h00005; rf[2] = 18'h00007;
    reset = 1'b0;
    run_op("add", mk(4'd0, 4'd3, 4'd1, 4'd2), 18'h0000C, 1'b0, 1'b0);
    chk("add.rf3", {14'd0, rf[3]}, 32'h0000C);

    // instr changes with instr_valid low must not start anything
    for (int i = 0; i < 3; i++) begin
      instr = 18'($urandom);
      @(negedge clock);
      chk("idle.hold", {31'd0, instr_ready}, 32'd1);
    end

    rf[1] = 18'h3FFFF; rf[2] = 18'h00001;
    run_op("add_ovf", mk(4'd0, 4'd4, 4'd1, 4'd2), 18'h00000, 1'b1, 1'b1);

    rf[1] = 18'h00005; rf[2] = 18'h00007;
    run_op("sub", mk(4'd1, 4'd5, 4'd1, 4'd2), 18'h3FFFE, 1'b0, 1'b1);

    rf[1] = 18'h00010;
    run_op("addi", {4'd5, 4'd6, 4'd1, 6'h3F}, 18'h0000F, 1'b0, 1'b1);

    run_illegal("ill_f", mk(4'hF, 4'd7, 4'd1, 4'd2), 18'h0000F, 1'b0, 1'b1);
    run_illegal("ill_7", mk(4'h7, 4'd7, 4'd1, 4'd2), 18'h0000F, 1'b0, 1'b1);
    chk("ill.rf7", {14'd0, rf[7]}, 32'd0);

    rf[1] = 18'h00004;
    run_op("add_self", mk(4'd0, 4'd1, 4'd1, 4'd1), 18'h00008, 1'b0, 1'b0);
    chk("add_self.rf1", {14'd0, rf[1]}, 32'h00008);

    rf[8] = 18'h0F0F0; rf[9] = 18'h00FF0;
    run_op("and", mk(4'd2, 4'd10, 4'd8, 4'd9), 18'h000F0, 1'b0, 1'b0);
    run_op("or",  mk(4'd3, 4'd11, 4'd8, 4'd9), 18'h0FFF0, 1'b0, 1'b0);
    run_op("xor", mk(4'd4, 4'd12, 4'd8, 4'd8), 18'h00000, 1'b1, 1'b0);
    run_op("mov", mk(4'd6, 4'd13, 4'd9, 4'd0), 18'h00FF0, 1'b0, 1'b0);

    // Reset in the middle of READ must drop the instruction.
    rf[1] = 18'h00005; rf[2] = 18'h00007; rf[3] = 18'h12345;
    accept(mk(4'd0, 4'd3, 4'd1, 4'd2));
    @(negedge clock);
    chk("mid.read_en", {31'd0, enable}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid.en",   {31'd0, enable}, 32'd0);
    chk("mid.rdy",  {31'd0, instr_ready}, 32'd1);
    chk("mid.dst",  {28'd0, reg_to_write}, 32'd0);
    chk("mid.data", {14'd0, data_to_write}, 32'd0);
    chk("mid.zero", {31'd0, zero_flag}, 32'd0);
    chk("mid.cy",   {31'd0, carry_flag}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    saw_load = load;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      saw_load = saw_load | load;
    end
    chk("mid.noload", {31'd0, saw_load}, 32'd0);
    chk("mid.rf3",    {14'd0, rf[3]}, 32'h12345);

    // Back-to-back with instr_valid held: accepts every 4 cycles.
    rf[1] = 18'h00001; rf[2] = 18'h00002;
    instr_valid = 1'b1;
    instr       = mk(4'd0, 4'd3, 4'd1, 4'd2);
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("b2b.rdy%0d", i), {31'd0, instr_ready}, {31'd0, (i % 4) == 0});
      chk($sformatf("b2b.done%0d", i), {31'd0, done}, {31'd0, ((i % 4) == 0) && (i > 0)});
      @(negedge clock);
    end
    instr_valid = 1'b0;
    repeat (4) @(negedge clock);
    wait_ready();
    chk("b2b.rf3", {14'd0, rf[3]}, 32'h00003);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
